if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch front end of the pipeline; it is the producer side of the IF/ID pipeline register.
- Owns the PC and issues one instruction-memory read at a time over a req/ready request channel and an rvalid response channel.
- Presents the fetched pc/inst pair, with a valid flag, to the IF/ID register.
- Honours the ID-stage stall and the branch redirect.

Parameters:
- ADDR_W, 32, instruction address / PC width.
- DATA_W, 32, instruction word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- stall  in  1  downstream hold; 1 = IF/ID does not consume the current output.
- branch_flag  in  1  redirect request from ID, one-cycle pulse.
- branch_target_address  in  ADDR_W  redirect target.
- inst_req  out  1  memory read request.
- inst_addr  out  ADDR_W  read address; equals pc.
- inst_ready  in  1  memory accepts the request (handshake = inst_req & inst_ready at posedge).
- inst_rvalid  in  1  read data valid.
- inst_rdata  in  DATA_W  read data.
- if_pc  out  ADDR_W  PC of the delivered instruction.
- if_inst  out  DATA_W  delivered instruction word.
- if_valid  out  1  if_pc/if_inst valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, discard=0.
  - inst_req=0, if_valid=0, if_pc=0, if_inst=0.
- All outputs are registered except inst_addr, which is driven directly from pc.
- States:
  - IDLE: the first posedge after reset release goes to REQ.
  - REQ: inst_req=1. On a handshake, go to WAIT.
  - WAIT: inst_req=0. Waits for inst_rvalid.
  - OUT: inst_req=0, if_valid=1.
- WAIT, on inst_rvalid with discard=0:
  - if_inst<=inst_rdata, if_pc<=pc, if_valid<=1.
  - pc<=pc+4 (modulo 2^ADDR_W; 0xFFFF_FFFC wraps to 0).
  - Go to OUT.
- WAIT, on inst_rvalid with discard=1: drop the data, discard<=0, go to REQ (pc already holds the target).
- OUT:
  - stall=1: hold if_pc/if_inst/if_valid unchanged.
  - stall=0: if_valid<=0, go to REQ.
- Minimum cadence is one instruction per 3 cycles with zero-wait memory (REQ, WAIT, OUT). inst_rvalid may arrive any number of cycles after acceptance.
- Branch (branch_flag=1). pc<=branch_target_address with bits [1:0] forced to 0. Branch always wins over stall.
  - IDLE: pc updated, go to REQ.
  - REQ without handshake: pc updated, stay in REQ. inst_addr changes the next cycle; an unaccepted request may change address.
  - REQ with handshake in the same cycle: the old address is in flight, so discard<=1 and go to WAIT.
  - WAIT without rvalid: discard<=1.
  - WAIT with rvalid in the same cycle: drop that data, go to REQ, discard stays 0.
  - OUT: if_valid<=0 (flush the undelivered instruction), go to REQ.
- inst_rvalid outside WAIT is ignored.
- At most one request is outstanding.
- stall has no effect in IDLE/REQ/WAIT.
- Reset asserted mid-transaction returns to the reset values immediately. Any late rvalid after reset release is ignored, because the state machine is not in WAIT until it issues again.

Test Plan:
- Reset release, zero-wait memory returning 0x24010001 at 0x0: inst_req at cycle 1 with addr 0x0, if_valid=1 with if_pc=0x0, if_inst=0x24010001 at cycle 3, next request addr 0x4 at cycle 4.
- stall=1 for 4 cycles while in OUT: if_pc/if_inst/if_valid frozen for 4 cycles, no inst_req; one cycle after stall drops, inst_req with addr+4.
- branch_flag with target 0x0000_0103 in the same cycle as the REQ handshake at 0x8: the response for 0x8 is dropped (if_valid stays 0), the next request addr is 0x100, and it is delivered with if_pc=0x100.
- branch_flag in OUT with stall=1, target 0x40: if_valid falls next cycle, inst_req with addr 0x40 follows.
- PC 0xFFFF_FFFC fetched: next request addr 0x0000_0000. inst_ready held low 5 cycles: inst_req stays high with a stable addr, no state change.
- rst pulled low while in WAIT, then memory returns rvalid after release: all outputs zero during reset, stray rvalid ignored, first request addr = RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, issues one read at a time to
// instruction memory and hands the fetched pc/inst pair to the IF/ID register.
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target_address,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ready,
  input  logic              inst_rvalid,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid
);

  // Request channel: a read is accepted on the rising edge where inst_req and
  // inst_ready are both high; inst_addr must hold while inst_req waits unless a
  // branch retargets it. The response is the single inst_rvalid cycle after it.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              discard, discard_n;
  logic              if_valid_n;
  logic [ADDR_W-1:0] if_pc_n;
  logic [DATA_W-1:0] if_inst_n;
  logic [ADDR_W-1:0] br_pc;

  assign br_pc     = branch_target_address & ~ADDR_W'(3);
  assign inst_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      inst_req <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      discard  <= discard_n;
      inst_req <= (state_n == REQ);
      if_valid <= if_valid_n;
      if_pc    <= if_pc_n;
      if_inst  <= if_inst_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    discard_n  = discard;
    if_valid_n = if_valid;
    if_pc_n    = if_pc;
    if_inst_n  = if_inst;
    case (state)
      IDLE: begin
        state_n = REQ;
        if (branch_flag) pc_n = br_pc;
      end
      REQ: begin
        if (branch_flag) pc_n = br_pc;
        if (inst_ready) begin
          state_n = WAIT;
          // Old address is already in flight; its data must be thrown away.
          if (branch_flag) discard_n = 1'b1;
        end
      end
      WAIT: begin
        if (branch_flag) pc_n = br_pc;
        if (inst_rvalid) begin
          if (discard || branch_flag) begin
            discard_n = 1'b0;
            state_n   = REQ;
          end else begin
            if_inst_n  = inst_rdata;
            if_pc_n    = pc;
            if_valid_n = 1'b1;
            pc_n       = pc + ADDR_W'(4);
            state_n    = OUT;
          end
        end else if (branch_flag) begin
          discard_n = 1'b1;
        end
      end
      OUT: begin
        if (branch_flag) begin
          pc_n       = br_pc;
          if_valid_n = 1'b0;
          state_n    = REQ;
        end else if (!stall) begin
          if_valid_n = 1'b0;
          state_n    = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a per-cycle vector table plus a hand-written
// long-latency response sequence.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target_address = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready = 1'b0;
  logic        inst_rvalid = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target_address(branch_target_address),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] tgt;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc, einst;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic s, logic b, logic [31:0] t, logic rdy,
                              logic rv, logic [31:0] rd, logic ereq,
                              logic [31:0] eaddr, logic evalid,
                              logic [31:0] epc, logic [31:0] einst);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.ready = rdy;
    v.rvalid = rv; v.rdata = rd; v.ereq = ereq; v.eaddr = eaddr;
    v.evalid = evalid; v.epc = epc; v.einst = einst;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall = v.stall; branch_flag = v.br;
    branch_target_address = v.tgt; inst_ready = v.ready;
    inst_rvalid = v.rvalid; inst_rdata = v.rdata;
  endtask

  initial begin
    //  rst s  b  tgt           rdy rv rdata          | req addr          vld pc            inst
    add(1, 0, 0, 0,            1, 0, 0,            0, 32'h0,         0, 32'h0,         32'h0);         // 0 IDLE
    add(1, 0, 0, 0,            1, 0, 0,            1, 32'h0,         0, 32'h0,         32'h0);         // 1 REQ
    add(1, 0, 0, 0,            0, 1, 32'h24010001, 0, 32'h0,         0, 32'h0,         32'h0);         // 2 WAIT
    add(1, 0, 0, 0,            0, 0, 0,            0, 32'h4,         1, 32'h0,         32'h24010001);  // 3 OUT
    add(1, 0, 0, 0,            1, 0, 0,            1, 32'h4,         0, 32'h0,         32'h24010001);
    add(1, 0, 0, 0,            0, 1, 32'h8c220004, 0, 32'h4,         0, 32'h0,         32'h24010001);
    for (int i = 0; i < 4; i++)                                                                      // stalled OUT
      add(1, 1, 0, 0,          0, 0, 0,            0, 32'h8,         1, 32'h4,         32'h8c220004);
    add(1, 0, 0, 0,            0, 0, 0,            0, 32'h8,         1, 32'h4,         32'h8c220004);
    add(1, 0, 1, 32'h103,      1, 0, 0,            1, 32'h8,         0, 32'h4,         32'h8c220004);  // branch + handshake
    add(1, 0, 0, 0,            0, 1, 32'hdeadbeef, 0, 32'h100,       0, 32'h4,         32'h8c220004);  // dropped
    add(1, 0, 0, 0,            1, 0, 0,            1, 32'h100,       0, 32'h4,         32'h8c220004);
    add(1, 0, 0, 0,            0, 1, 32'h00000013, 0, 32'h100,       0, 32'h4,         32'h8c220004);
    add(1, 1, 1, 32'h40,       0, 0, 0,            0, 32'h104,       1, 32'h100,       32'h13);        // branch in stalled OUT
    for (int i = 0; i < 5; i++)                                                                      // ready low
      add(1, 0, 0, 0,          0, 0, 0,            1, 32'h40,        0, 32'h100,       32'h13);
    add(1, 0, 0, 0,            1, 0, 0,            1, 32'h40,        0, 32'h100,       32'h13);
    add(1, 0, 0, 0,            0, 1, 32'h11111111, 0, 32'h40,        0, 32'h100,       32'h13);
    add(1, 0, 0, 0,            0, 0, 0,            0, 32'h44,        1, 32'h40,        32'h11111111);
    add(1, 0, 1, 32'hfffffffe, 0, 0, 0,            1, 32'h44,        0, 32'h40,        32'h11111111);  // retarget unaccepted req
    add(1, 0, 0, 0,            1, 0, 0,            1, 32'hfffffffc,  0, 32'h40,        32'h11111111);
    add(1, 0, 0, 0,            0, 1, 32'haaaa5555, 0, 32'hfffffffc,  0, 32'h40,        32'h11111111);
    add(1, 0, 0, 0,            0, 0, 0,            0, 32'h0,         1, 32'hfffffffc,  32'haaaa5555);  // pc wrap
    add(1, 0, 0, 0,            1, 0, 0,            1, 32'h0,         0, 32'hfffffffc,  32'haaaa5555);
    add(1, 0, 0, 0,            0, 1, 32'h22222222, 0, 32'h0,         0, 32'hfffffffc,  32'haaaa5555);
    add(1, 0, 0, 0,            0, 0, 0,            0, 32'h4,         1, 32'h0,         32'h22222222);
    add(1, 0, 0, 0,            1, 0, 0,            1, 32'h4,         0, 32'h0,         32'h22222222);
    add(0, 0, 0, 0,            0, 0, 0,            0, 32'h0,         0, 32'h0,         32'h0);         // reset in WAIT
    add(0, 0, 0, 0,            0, 0, 0,            0, 32'h0,         0, 32'h0,         32'h0);
    add(1, 0, 0, 0,            0, 1, 32'h33333333, 0, 32'h0,         0, 32'h0,         32'h0);         // stray rvalid
    add(1, 0, 0, 0,            0, 1, 32'h33333333, 1, 32'h0,         0, 32'h0,         32'h0);
    add(1, 0, 0, 0,            1, 0, 0,            1, 32'h0,         0, 32'h0,         32'h0);
    add(1, 0, 0, 0,            0, 1, 32'h44444444, 0, 32'h0,         0, 32'h0,         32'h0);
    add(1, 0, 0, 0,            0, 0, 0,            0, 32'h4,         1, 32'h0,         32'h44444444);
    add(1, 0, 0, 0,            1, 0, 0,            1, 32'h4,         0, 32'h0,         32'h44444444);
    add(1, 0, 1, 32'h200,      0, 0, 0,            0, 32'h4,         0, 32'h0,         32'h44444444);  // branch in WAIT
    add(1, 0, 0, 0,            0, 1, 32'h55555555, 0, 32'h200,       0, 32'h0,         32'h44444444);  // dropped
    add(1, 0, 0, 0,            1, 0, 0,            1, 32'h200,       0, 32'h0,         32'h44444444);
    add(1, 0, 0, 0,            0, 1, 32'h66666666, 0, 32'h200,       0, 32'h0,         32'h44444444);
    add(1, 0, 0, 0,            0, 0, 0,            0, 32'h204,       1, 32'h200,       32'h66666666);

    repeat (3) @(posedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d inst_req", i),  {31'b0, inst_req}, {31'b0, tbl[i].ereq});
      chk($sformatf("vec%0d inst_addr", i), inst_addr,         tbl[i].eaddr);
      chk($sformatf("vec%0d if_valid", i),  {31'b0, if_valid}, {31'b0, tbl[i].evalid});
      chk($sformatf("vec%0d if_pc", i),     if_pc,             tbl[i].epc);
      chk($sformatf("vec%0d if_inst", i),   if_inst,           tbl[i].einst);
    end

    // Long-latency response: request at 0x204, data arrives 6 cycles later.
    @(negedge clk);
    stall = 0; branch_flag = 0; inst_rvalid = 0; inst_ready = 1;
    #1;
    chk("lat req", {31'b0, inst_req}, 32'd1);
    chk("lat addr", inst_addr, 32'h204);
    @(negedge clk);
    inst_ready = 0;
    repeat (6) begin
      #1;
      chk("lat wait idle", {30'b0, inst_req, if_valid}, 32'd0);
      @(negedge clk);
    end
    inst_rvalid = 1; inst_rdata = 32'h77777777;
    @(negedge clk);
    inst_rvalid = 0;
    begin
      int budget = 10;
      while (!if_valid && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      chk("lat timeout", {31'b0, if_valid}, 32'd1);
    end
    chk("lat if_pc", if_pc, 32'h204);
    chk("lat if_inst", if_inst, 32'h77777777);
    @(negedge clk);
    #1;
    chk("lat next req", {31'b0, inst_req}, 32'd1);
    chk("lat next addr", inst_addr, 32'h208);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
